// File: rtl/qracc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// qracc_layer_sequencer : fetch / MAC issue / writeback sequencer for one layer
// Revision 1.0
// ============================================================================
module qracc_layer_sequencer #(
  parameter int inputBits      = 4,
  parameter int inputElements  = 128,
  parameter int outputBits     = 8,
  parameter int outputElements = 32,
  parameter int busWidth       = 32,
  parameter int addrWidth      = 32,
  parameter int cntWidth       = 16
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                start_i,
  input  logic                                abort_i,
  input  logic [addrWidth-1:0]                cfg_in_base_i,
  input  logic [addrWidth-1:0]                cfg_out_base_i,
  input  logic [cntWidth-1:0]                 cfg_num_vectors_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                rd_en_o,
  output logic [addrWidth-1:0]                rd_addr_o,
  input  logic [busWidth-1:0]                 rd_data_i,
  output logic                                wr_en_o,
  output logic [addrWidth-1:0]                wr_addr_o,
  output logic [busWidth-1:0]                 wr_data_o,
  input  logic                                wr_ready_i,
  output logic [inputElements*inputBits-1:0]  mac_data_o,
  output logic                                mac_valid_o,
  input  logic                                acc_ready_i,
  input  logic                                acc_valid_i,
  input  logic [outputElements*outputBits-1:0] acc_data_i
);

  localparam int MW  = inputElements * inputBits;
  localparam int RW  = outputElements * outputBits;
  localparam int IW  = MW / busWidth;
  localparam int OW  = RW / busWidth;
  localparam int BPW = busWidth / 8;
  localparam int KW  = (IW > 1) ? $clog2(IW) : 1;
  localparam int JW  = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [KW-1:0]        K_LAST = KW'(IW - 1);
  localparam logic [JW-1:0]        J_LAST = JW'(OW - 1);
  localparam logic [addrWidth-1:0] A_STEP = addrWidth'(BPW);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4
  } state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_en_q;
  logic [addrWidth-1:0]   rd_addr_q;
  logic                   rd_pend_q;
  logic [KW-1:0]          rd_k_q;
  logic [KW-1:0]          cap_k_q;
  logic [MW-1:0]          mac_data_q;
  logic                   mac_valid_q;
  logic [RW-1:0]          outreg_q;
  logic                   wr_en_q;
  logic [addrWidth-1:0]   wr_addr_q;
  logic [busWidth-1:0]    wr_data_q;
  logic [JW-1:0]          wr_j_q;
  logic [cntWidth-1:0]    v_q;
  logic [cntWidth-1:0]    num_q;

  logic [cntWidth-1:0]    v_d;
  logic [JW-1:0]          j_d;

  assign v_d = v_q + 1'b1;
  assign j_d = wr_j_q + 1'b1;

  // The address registers double as running pointers: each vector's block
  // starts exactly one word past the previous vector's last word.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_k_q      <= '0;
      cap_k_q     <= '0;
      mac_data_q  <= '0;
      mac_valid_q <= 1'b0;
      outreg_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_j_q      <= '0;
      v_q         <= '0;
      num_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= rd_en_q;
      if (abort_i && (state_q != S_IDLE)) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        rd_en_q     <= 1'b0;
        rd_pend_q   <= 1'b0;
        mac_valid_q <= 1'b0;
        wr_en_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              if (cfg_num_vectors_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q   <= S_FETCH;
                busy_q    <= 1'b1;
                num_q     <= cfg_num_vectors_i;
                v_q       <= '0;
                rd_addr_q <= cfg_in_base_i;
                wr_addr_q <= cfg_out_base_i;
                rd_en_q   <= 1'b1;
                rd_k_q    <= '0;
                cap_k_q   <= '0;
              end
            end
          end

          S_FETCH: begin
            if (rd_en_q) begin
              rd_addr_q <= rd_addr_q + A_STEP;
              if (rd_k_q == K_LAST) begin
                rd_en_q <= 1'b0;
                rd_k_q  <= '0;
              end else begin
                rd_k_q <= rd_k_q + 1'b1;
              end
            end
            // Read data lags its strobe by one cycle.
            if (rd_pend_q) begin
              mac_data_q[int'(cap_k_q)*busWidth +: busWidth] <= rd_data_i;
              if (cap_k_q == K_LAST) begin
                cap_k_q     <= '0;
                state_q     <= S_ISSUE;
                mac_valid_q <= 1'b1;
              end else begin
                cap_k_q <= cap_k_q + 1'b1;
              end
            end
          end

          S_ISSUE: begin
            if (acc_ready_i) begin
              mac_valid_q <= 1'b0;
              state_q     <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (acc_valid_i) begin
              outreg_q  <= acc_data_i;
              wr_data_q <= acc_data_i[busWidth-1:0];
              wr_en_q   <= 1'b1;
              wr_j_q    <= '0;
              state_q   <= S_STORE;
            end
          end

          S_STORE: begin
            if (wr_ready_i) begin
              wr_addr_q <= wr_addr_q + A_STEP;
              if (wr_j_q == J_LAST) begin
                wr_en_q <= 1'b0;
                wr_j_q  <= '0;
                v_q     <= v_d;
                if (v_d == num_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_FETCH;
                  rd_en_q <= 1'b1;
                end
              end else begin
                wr_j_q    <= j_d;
                wr_data_q <= outreg_q[int'(j_d)*busWidth +: busWidth];
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign mac_data_o  = mac_data_q;
  assign mac_valid_o = mac_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_qracc_layer_sequencer.sv
`default_nettype none
// tb_qracc_layer_sequencer : directed self-checking bench with buffer and
// echoing accelerator responders.
module tb_qracc_layer_sequencer;

  localparam int MW = 512;
  localparam int RW = 256;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] cfg_in_base_i;
  logic [AW-1:0] cfg_out_base_i;
  logic [CW-1:0] cfg_num_vectors_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [BW-1:0] rd_data_i = '0;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [BW-1:0] wr_data_o;
  logic          wr_ready_i = 1'b1;
  logic [MW-1:0] mac_data_o;
  logic          mac_valid_o;
  logic          acc_ready_i = 1'b1;
  logic          acc_valid_i;
  logic [RW-1:0] acc_data_i;

  logic          model_valid;
  logic [RW-1:0] model_data = '0;
  logic          spur_v = 1'b0;
  logic [RW-1:0] spur_d = '0;
  int            acc_cnt = 0;
  int            acc_lat = 3;
  logic [AW-1:0] mem_base = '0;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            done_cyc = 0;
  int            last_wr_cyc = 0;
  int            done_cnt = 0;
  int            stall_cnt = 0;
  int            mv_cycles = 0;
  int            mv_changed = 0;
  int            hold_req = 0;
  int            hold_cnt = 0;
  bit            bp_mode = 1'b0;
  int            bp_idx = 0;
  logic          prev_mv = 1'b0;
  logic [MW-1:0] prev_md = '0;
  logic [MW-1:0] hs_data = '0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wa_log[$];
  logic [BW-1:0] wd_log[$];

  qracc_layer_sequencer dut (
    .clk               (clk),
    .nrst              (nrst),
    .start_i           (start_i),
    .abort_i           (abort_i),
    .cfg_in_base_i     (cfg_in_base_i),
    .cfg_out_base_i    (cfg_out_base_i),
    .cfg_num_vectors_i (cfg_num_vectors_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .rd_en_o           (rd_en_o),
    .rd_addr_o         (rd_addr_o),
    .rd_data_i         (rd_data_i),
    .wr_en_o           (wr_en_o),
    .wr_addr_o         (wr_addr_o),
    .wr_data_o         (wr_data_o),
    .wr_ready_i        (wr_ready_i),
    .mac_data_o        (mac_data_o),
    .mac_valid_o       (mac_valid_o),
    .acc_ready_i       (acc_ready_i),
    .acc_valid_i       (acc_valid_i),
    .acc_data_i        (acc_data_i)
  );

  always #5 clk = ~clk;

  // Buffer word i (relative to the programmed input base) holds the value i.
  always @(posedge clk) rd_data_i <= rd_en_o ? ((rd_addr_o - mem_base) >> 2) : '0;

  // Accelerator echoes the low RW bits of the request, acc_lat cycles later.
  always @(posedge clk) begin
    if (mac_valid_o && acc_ready_i) begin
      model_data <= mac_data_o[RW-1:0];
      acc_cnt    <= acc_lat;
    end else if (acc_cnt > 0) begin
      acc_cnt <= acc_cnt - 1;
    end
  end
  assign model_valid = (acc_cnt == 1);
  assign acc_valid_i = model_valid | spur_v;
  assign acc_data_i  = spur_v ? spur_d : model_data;

  always @(negedge clk) begin
    if (!mac_valid_o) begin
      hold_cnt    = hold_req;
      acc_ready_i = 1'b1;
    end else if (hold_cnt > 0) begin
      acc_ready_i = 1'b0;
      hold_cnt    = hold_cnt - 1;
    end else begin
      acc_ready_i = 1'b1;
    end
  end

  // Write-ready pattern 1,0,0,1 repeating over STORE cycles.
  always @(negedge clk) begin
    if (!bp_mode) begin
      bp_idx     = 0;
      wr_ready_i = 1'b1;
    end else if (wr_en_o) begin
      wr_ready_i = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
      bp_idx     = bp_idx + 1;
    end else begin
      wr_ready_i = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (nrst) begin
      if (start_i && !busy_o && !abort_i) start_cyc = cyc;
      if (rd_en_o) rd_log.push_back(rd_addr_o);
      if (wr_en_o && wr_ready_i) begin
        wa_log.push_back(wr_addr_o);
        wd_log.push_back(wr_data_o);
        last_wr_cyc = cyc;
      end
      if (wr_en_o && !wr_ready_i) stall_cnt = stall_cnt + 1;
      if (mac_valid_o) mv_cycles = mv_cycles + 1;
      if (mac_valid_o && prev_mv && (mac_data_o !== prev_md)) mv_changed = mv_changed + 1;
      if (mac_valid_o && acc_ready_i) hs_data = mac_data_o;
      if (done_o) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      prev_mv = mac_valid_o;
      prev_md = mac_data_o;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int limit, input string tag);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt != base, 1);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    mv_cycles  = 0;
    mv_changed = 0;
    stall_cnt  = 0;
  endtask

  task automatic run_layer(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                           input logic [CW-1:0] nv, input int hold, input bit bp,
                           input string tag);
    int done_base;
    clear_logs();
    hold_req = hold;
    bp_mode  = bp;
    mem_base = ib;
    cfg_in_base_i     = ib;
    cfg_out_base_i    = ob;
    cfg_num_vectors_i = nv;
    done_base = done_cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    // Configuration changes while busy must not disturb the layer.
    cfg_in_base_i     = 32'hDEAD_0000;
    cfg_out_base_i    = 32'hBEEF_0000;
    cfg_num_vectors_i = 16'd7;
    wait_done(4000, {tag, "_done_seen"});
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    bp_mode  = 1'b0;
    hold_req = 0;
  endtask

  task automatic check_single(input string tag, input logic [AW-1:0] ib, input int dur);
    check({tag, "_rd_count"}, rd_log.size(), 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_rd_addr%0d", tag, k), rd_log[k], ib + 32'(k * 4));
      check($sformatf("%s_mac_w%0d", tag, k), hs_data[k*32 +: 32], k);
    end
    check({tag, "_wr_count"}, wa_log.size(), 8);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("%s_wr_addr%0d", tag, j), wa_log[j], 32'h800 + 32'(j * 4));
      check($sformatf("%s_wr_data%0d", tag, j), wd_log[j], j);
    end
    check({tag, "_duration"}, done_cyc - start_cyc, dur);
    check({tag, "_busy_after"}, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr_before;
    int rd_before;
    int done_before;
    logic [RW-1:0] exp_or;

    nrst = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    cfg_in_base_i = '0;
    cfg_out_base_i = '0;
    cfg_num_vectors_i = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_mac_valid", mac_valid_o, 0);
    check("rst_mac_data", mac_data_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic single-vector layer.
    run_layer(32'h100, 32'h800, 16'd1, 0, 1'b0, "basic");
    check_single("basic", 32'h100, 30);
    check("basic_mv_cycles", mv_cycles, 1);

    // Three vectors: 48 reads, 24 writes, one done after the last write.
    run_layer(32'h100, 32'h800, 16'd3, 0, 1'b0, "multi");
    check("multi_rd_count", rd_log.size(), 48);
    check("multi_v2_rd", rd_log[32], 32'h180);
    check("multi_last_rd", rd_log[47], 32'h1BC);
    check("multi_wr_count", wa_log.size(), 24);
    check("multi_v2_wr", wa_log[16], 32'h840);
    check("multi_last_wr", wa_log[23], 32'h85C);
    check("multi_last_data", wd_log[23], 39);
    check("multi_done_after_wr", done_cyc - last_wr_cyc, 1);
    check("multi_duration", done_cyc - start_cyc, 88);

    // Backpressure: 5 stalled ISSUE cycles and a 1,0,0,1 write-ready pattern.
    run_layer(32'h100, 32'h800, 16'd1, 5, 1'b1, "bp");
    check_single("bp", 32'h100, 43);
    check("bp_mv_cycles", mv_cycles, 6);
    check("bp_mac_stable", mv_changed, 0);
    check("bp_stalls", stall_cnt, 8);

    // Zero-length layer.
    run_layer(32'h100, 32'h800, 16'd0, 0, 1'b0, "zero");
    check("zero_duration", done_cyc - start_cyc, 1);
    check("zero_rd_count", rd_log.size(), 0);
    check("zero_wr_count", wa_log.size(), 0);

    // Input address wrap-around.
    run_layer(32'hFFFF_FFF8, 32'h800, 16'd1, 0, 1'b0, "wrap");
    check("wrap_rd0", rd_log[0], 32'hFFFF_FFF8);
    check("wrap_rd2", rd_log[2], 32'h0000_0000);
    check("wrap_wr_data7", wd_log[7], 7);

    // Abort in the 10th FETCH cycle.
    clear_logs();
    mem_base = 32'h100;
    cfg_in_base_i = 32'h100;
    cfg_out_base_i = 32'h800;
    cfg_num_vectors_i = 16'd2;
    done_before = done_cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_rd_en", rd_en_o, 0);
    check("abort_mac_valid", mac_valid_o, 0);
    check("abort_rd_count", rd_log.size(), 10);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - done_before, 0);
    check("abort_no_more_rd", rd_log.size(), 10);
    check("abort_no_wr", wa_log.size(), 0);
    run_layer(32'h100, 32'h800, 16'd1, 0, 1'b0, "post_abort");
    check_single("post_abort", 32'h100, 30);

    // Asynchronous reset while storing.
    clear_logs();
    mem_base = 32'h100;
    cfg_in_base_i = 32'h100;
    cfg_out_base_i = 32'h800;
    cfg_num_vectors_i = 16'd1;
    done_before = done_cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!wr_en_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_store", wr_en_o, 1);
    @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_rd_en", rd_en_o, 0);
    check("arst_rd_addr", rd_addr_o, 0);
    check("arst_wr_en", wr_en_o, 0);
    check("arst_wr_addr", wr_addr_o, 0);
    check("arst_wr_data", wr_data_o, 0);
    check("arst_mac_valid", mac_valid_o, 0);
    check("arst_mac_data", mac_data_o, 0);
    wr_before = wa_log.size();
    rd_before = rd_log.size();
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_done", done_cnt - done_before, 0);
    check("arst_no_more_wr", wa_log.size(), wr_before);
    check("arst_no_more_rd", rd_log.size(), rd_before);
    run_layer(32'h100, 32'h800, 16'd1, 0, 1'b0, "post_rst");
    check_single("post_rst", 32'h100, 30);

    // Spurious result while idle must not touch the output register.
    for (int j = 0; j < 8; j++) exp_or[j*32 +: 32] = 32'(j);
    done_before = done_cnt;
    wr_before = wa_log.size();
    spur_d = {RW{1'b1}};
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_outreg", dut.outreg_q, exp_or);
    check("spur_busy", busy_o, 0);
    check("spur_no_wr", wa_log.size(), wr_before);
    check("spur_no_done", done_cnt - done_before, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qracc_layer_sequencer.md
# qracc_layer_sequencer

- Sequences one layer of matrix-vector work through the QR accelerator for a programmed count of input vectors.
- For each vector it reads packed activations from the global buffer and issues one MAC request to the sequential accelerator.
- It then writes the returned outputs back to the buffer and advances to the next vector.
- It sits between the CSR block, the global buffer ports and the accelerator's MAC handshake, and is generalised in element count, bit widths and bus width.

## Interface
- inputBits, 4, bits per input activation
- inputElements, 128, activations per MAC vector
- outputBits, 8, bits per output element
- outputElements, 32, outputs per MAC result
- busWidth, 32, global buffer data width. inputElements*inputBits and outputElements*outputBits must be multiples of busWidth.
- addrWidth, 32, byte address width
- cntWidth, 16, vector counter width
- Derived: IW = inputElements*inputBits/busWidth (default 16), OW = outputElements*outputBits/busWidth (default 8), BPW = busWidth/8
- clk  in  1  sole clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- abort_i  in  1  abandon the current layer
- cfg_in_base_i  in  addrWidth  input byte base address
- cfg_out_base_i  in  addrWidth  output byte base address
- cfg_num_vectors_i  in  cntWidth  number of vectors in the layer
- busy_o  out  1  high whenever the state is not IDLE
- done_o  out  1  one-cycle completion pulse
- rd_en_o  out  1  buffer read strobe
- rd_addr_o  out  addrWidth  read byte address
- rd_data_i  in  busWidth  read data, valid exactly 1 cycle after rd_en_o
- wr_en_o  out  1  buffer write request
- wr_addr_o  out  addrWidth  write byte address
- wr_data_o  out  busWidth  write data
- wr_ready_i  in  1  buffer accepts the write when wr_en_o && wr_ready_i
- mac_data_o  out  inputElements*inputBits  packed input vector
- mac_valid_o  out  1  MAC request valid
- acc_ready_i  in  1  accelerator ready
- acc_valid_i  in  1  accelerator result valid
- acc_data_i  in  outputElements*outputBits  accelerator result

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, STORE.
- IDLE
  - On start_i with cfg_num_vectors_i != 0: latch all cfg_* inputs, clear vector count v, go to FETCH.
  - On start_i with cfg_num_vectors_i == 0: pulse done_o on the next cycle and stay in IDLE.
- FETCH
  - rd_en_o is high for IW consecutive cycles, k = 0..IW-1.
  - rd_addr_o = in_base + (v*IW + k)*BPW, truncated to addrWidth (wrap-around allowed).
  - Each rd_data_i is written into mac_data_o[k*busWidth +: busWidth].
  - The state moves to ISSUE on the cycle after the last data word is captured.
- ISSUE
  - mac_valid_o is high, with mac_data_o held stable.
  - On mac_valid_o && acc_ready_i, go to WAIT; mac_valid_o drops on the next cycle.
- WAIT
  - On acc_valid_i, register acc_data_i into the output register and go to STORE.
  - acc_valid_i is ignored in every other state.
- STORE
  - wr_en_o is high for output word j = 0..OW-1.
  - wr_data_o = outreg[j*busWidth +: busWidth].
  - wr_addr_o = out_base + (v*OW + j)*BPW, wrapping.
  - j advances only on wr_en_o && wr_ready_i; address and data hold while wr_ready_i is low.
  - After the last accepted word, v increments. If v == num_vectors, pulse done_o and go to IDLE; otherwise go to FETCH.
- Abort
  - abort_i while in any non-IDLE state takes effect at the next edge: go to IDLE, drop all strobes, no done_o pulse.
  - An in-flight read response arriving after an abort is ignored.
  - abort_i has priority over start_i.
- Configuration stability: changing cfg_* inputs while busy_o is high has no effect.
- Counter limits: v and num_vectors are cntWidth bits; the maximum layer is 2^cntWidth - 1 vectors.

## Timing
- Reset values: every output is 0, including mac_data_o and done_o; the state is IDLE.
- Asynchronous reset mid-operation returns to IDLE immediately; there is no done_o pulse and no further strobes.
- All outputs are registered; there are no combinational paths from input to output.
- Start to first rd_en_o: 1 cycle (start_i sampled at edge n, rd_en_o high in cycle n+1).
- FETCH duration: IW+1 cycles.
- ISSUE duration: 1 cycle minimum; it stretches while acc_ready_i is low.
- STORE duration: OW cycles with wr_ready_i held high.
- Per-vector cycle count, with accelerator latency L cycles from handshake to acc_valid_i: IW + 1 + 1 + L + OW, which is 26 + L at the defaults.
- done_o is asserted the cycle after the final write handshake; busy_o falls in that same cycle.
- start_i is accepted again from the cycle in which done_o is high.

## Test plan
- Basic layer
  - Stimulus: defaults, num_vectors=1, in_base=0x100, out_base=0x800, buffer word i = i, accelerator echoes with L=3, wr_ready_i=1.
  - Required response: 16 reads at 0x100..0x13C; mac_data_o word k = k; 8 writes at 0x800..0x81C; done_o high exactly 30 cycles after start.
- Multi-vector addressing
  - Stimulus: num_vectors=3.
  - Required response: vector 2 reads start at 0x180 and writes start at 0x840; exactly one done_o pulse, after the 24th write.
- Backpressure
  - Stimulus: hold acc_ready_i low 5 cycles in ISSUE; toggle wr_ready_i 1,0,0,1.
  - Required response: mac_valid_o and mac_data_o stay stable; no write address skipped or duplicated; total duration grows by exactly the stall cycles.
- Zero-length and wrap-around
  - Stimulus: num_vectors=0.
  - Required response: done_o pulses 1 cycle after start with no rd_en_o or wr_en_o.
  - Stimulus: in_base=0xFFFFFFF8.
  - Required response: third read address is 0x00000000.
- Abort, reset and spurious result
  - Stimulus: abort_i asserted in the 10th FETCH cycle.
  - Required response: IDLE next cycle, busy_o=0, no done_o; a following start runs cleanly.
  - Stimulus: nrst asserted during STORE.
  - Required response: all outputs are 0 asynchronously.
  - Stimulus: acc_valid_i pulsed while in IDLE.
  - Required response: ignored, and the output register is unchanged.
